// File: rtl/btn_pkg.sv
// Shared types and sizing helper for the btn_scan_ctrl debounce controller.
package btn_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } chan_state_e;

  typedef struct packed {
    logic press;
    logic long_press;
  } btn_evt_t;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One debounce channel: 2-flop synchronizer, tick-driven debounce FSM and,
// when BTN_LONG_PRESS_EN is defined, a saturating long-press tick counter.
module btn_chan
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int LONG_TICKS = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     raw,
  input  logic     tick,
  output logic     level,
  output logic     post,
  output btn_evt_t evt
);

  localparam int CNT_W = cnt_width(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  if (STABLE_CNT < 1 || STABLE_CNT > 15 || LONG_TICKS < 1) begin : g_bad_param
    $error("btn_chan: STABLE_CNT or LONG_TICKS out of range");
  end

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_entry;

`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_W = cnt_width(LONG_TICKS);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
`endif

  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    press_entry = 1'b0;
    post        = 1'b0;
    evt         = '0;
    if (tick) begin
      case (state_q)
        ZERO: if (sync2_q) begin
          if (STABLE_CNT == 1) begin
            state_d     = ONE;
            press_entry = 1'b1;
          end else begin
            state_d = WAIT1;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT1: begin
          if (!sync2_q) begin
            state_d = ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d     = ONE;
            press_entry = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ONE: if (!sync2_q) begin
          if (STABLE_CNT == 1) begin
            state_d = ZERO;
            level_d = 1'b0;
            post    = 1'b1;
          end else begin
            state_d = WAIT0;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT0: begin
          // Bouncing back high returns to ONE silently: no second press.
          if (sync2_q) begin
            state_d = ONE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ZERO;
            level_d = 1'b0;
            post    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ZERO;
      endcase
    end
    if (press_entry) begin
      level_d   = 1'b1;
      post      = 1'b1;
      evt.press = 1'b1;
    end
`ifdef BTN_LONG_PRESS_EN
    long_cnt_d = long_cnt_q;
    if (press_entry) begin
      long_cnt_d = '0;
    end else if (tick && state_q == ONE && sync2_q && long_cnt_q != LONG_MAX) begin
      long_cnt_d = long_cnt_q + 1'b1;
      if (long_cnt_q == LONG_MAX - 1'b1) begin
        post           = 1'b1;
        evt.press      = 1'b1;
        evt.long_press = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      long_cnt_q <= '0;
    end else begin
      long_cnt_q <= long_cnt_d;
    end
  end
`endif

  assign level = level_q;

endmodule

// File: rtl/btn_scan_ctrl.sv
// Multi-button debounce controller: shared tick prescaler, per-button channels,
// one-deep pending slots and a round-robin event port. Long press needs BTN_LONG_PRESS_EN.
module btn_scan_ctrl
  import btn_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int TICK_W     = 2,
  parameter int STABLE_CNT = 3,
  parameter int LONG_TICKS = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic                       evt_press,
  output logic                       evt_long,
  output logic                       evt_ovf
);

  localparam int ID_W = $clog2(NUM_BTN);

  logic [TICK_W-1:0]  presc_q, presc_d;
  logic               tick;
  logic [NUM_BTN-1:0] post;
  btn_evt_t           post_evt [NUM_BTN];
  logic [NUM_BTN-1:0] pend_q, pend_d, avail;
  btn_evt_t           pend_evt_q [NUM_BTN];
  btn_evt_t           pend_evt_d [NUM_BTN];
  logic [ID_W-1:0]    ptr_q, ptr_d, sel, cand;
  logic               evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic               evt_press_q, evt_press_d;
  logic               evt_long_q, evt_long_d;
  logic               evt_ovf_q, evt_ovf_d;
  logic               hs, found;

  assign tick = &presc_q;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_chan #(
      .STABLE_CNT(STABLE_CNT),
      .LONG_TICKS(LONG_TICKS)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (btn_raw[gi]),
      .tick   (tick),
      .level  (btn_level[gi]),
      .post   (post[gi]),
      .evt    (post_evt[gi])
    );
  end

  always_comb begin
    presc_d     = presc_q + 1'b1;
    hs          = evt_valid_q & evt_ready;
    pend_d      = pend_q;
    pend_evt_d  = pend_evt_q;
    ptr_d       = ptr_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_press_d = evt_press_q;
    evt_long_d  = evt_long_q;
    evt_ovf_d   = evt_ovf_q;
    found       = 1'b0;
    sel         = '0;
    cand        = '0;
    if (hs) begin
      pend_d[evt_id_q] = 1'b0;
      ptr_d = (int'(evt_id_q) == NUM_BTN - 1) ? '0 : evt_id_q + 1'b1;
    end
    // Only slots filled before this edge compete; fresh posts show up next cycle.
    avail = pend_d;
    if (!evt_valid_q || hs) begin
      for (int k = 0; k < NUM_BTN; k++) begin
        cand = ID_W'((int'(ptr_d) + k) % NUM_BTN);
        if (!found && avail[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
      evt_valid_d = found;
      if (found) begin
        evt_id_d    = sel;
        evt_press_d = pend_evt_q[sel].press;
        evt_long_d  = pend_evt_q[sel].long_press;
      end
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      if (post[i]) begin
        if (pend_d[i]) begin
          evt_ovf_d = 1'b1;
        end else begin
          pend_d[i]     = 1'b1;
          pend_evt_d[i] = post_evt[i];
        end
      end
    end
`ifndef BTN_LONG_PRESS_EN
    evt_long_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      pend_q      <= '0;
      pend_evt_q  <= '{default: '0};
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_press_q <= 1'b0;
      evt_long_q  <= 1'b0;
      evt_ovf_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pend_q      <= pend_d;
      pend_evt_q  <= pend_evt_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_press_q <= evt_press_d;
      evt_long_q  <= evt_long_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_press = evt_press_q;
  assign evt_long  = evt_long_q;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Bench for btn_scan_ctrl: directed scenarios plus random button/ready traffic,
// checked every cycle against a run-length debounce and slot/round-robin model.
module tb_btn_scan_ctrl;

  localparam int N      = 4;
  localparam int TICK_W = 2;
  localparam int STABLE = 3;
  localparam int LONG   = 16;
  localparam int TICK_P = 1 << TICK_W;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic         evt_ready = 1'b0;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_press, evt_long, evt_ovf;

  always #5 clk = ~clk;

  btn_scan_ctrl #(
    .NUM_BTN(N), .TICK_W(TICK_W), .STABLE_CNT(STABLE), .LONG_TICKS(LONG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_press(evt_press), .evt_long(evt_long), .evt_ovf(evt_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a level flips after STABLE consecutive disagreeing ticks.
  int           m_edge;
  bit [N-1:0]   m_level, m_prev1, m_prev2, m_pend;
  int           m_run [N];
  int           m_long [N];
  bit           m_pend_press [N];
  bit           m_pend_long [N];
  bit           m_valid, m_press, m_long_o, m_ovf;
  int           m_id, m_ptr;
  int           hs_log[$];
  int           hs_cyc[$];
  int           cyc;

  task automatic model_reset();
    m_edge = 0; m_level = '0; m_prev1 = '0; m_prev2 = '0; m_pend = '0;
    m_valid = 0; m_press = 0; m_long_o = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_long[i] = 0; m_pend_press[i] = 0; m_pend_long[i] = 0;
    end
    hs_log.delete(); hs_cyc.delete(); cyc = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw, input logic rdy);
    bit         tick;
    bit [N-1:0] avail;
    bit         s, posted, pp, pl;
    tick = ((m_edge % TICK_P) == TICK_P - 1);
    m_edge++;
    avail = m_pend;
    if (m_valid && rdy) begin
      avail[m_id] = 1'b0;
      m_ptr = (m_id + 1) % N;
    end
    if (!m_valid || rdy) begin
      m_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (avail[(m_ptr + k) % N]) begin
          m_valid  = 1'b1;
          m_id     = (m_ptr + k) % N;
          m_press  = m_pend_press[m_id];
          m_long_o = m_pend_long[m_id];
          break;
        end
      end
    end
    m_pend = avail;
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        s = m_prev2[i]; posted = 0; pp = 0; pl = 0;
        if (s != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == STABLE) begin
            m_level[i] = s; m_run[i] = 0; posted = 1; pp = s;
            if (s) m_long[i] = 0;
          end
        end else begin
`ifdef BTN_LONG_PRESS_EN
          if (m_level[i] && m_run[i] == 0 && m_long[i] < LONG) begin
            m_long[i]++;
            if (m_long[i] == LONG) begin posted = 1; pp = 1; pl = 1; end
          end
`endif
          m_run[i] = 0;
        end
        if (posted) begin
          if (m_pend[i]) m_ovf = 1'b1;
          else begin m_pend[i] = 1'b1; m_pend_press[i] = pp; m_pend_long[i] = pl; end
        end
      end
    end
    m_prev2 = m_prev1;
    m_prev1 = raw;
  endtask

  task automatic compare_all();
    chk("btn_level", btn_level, m_level);
    chk("evt_valid", evt_valid, m_valid);
    chk("evt_ovf", evt_ovf, m_ovf);
    if (m_valid) begin
      chk("evt_id", evt_id, m_id);
      chk("evt_press", evt_press, m_press);
      chk("evt_long", evt_long, m_long_o);
    end
  endtask

  task automatic step(input logic [N-1:0] raw, input logic rdy);
    btn_raw = raw; evt_ready = rdy;
    #1;
    if (evt_valid === 1'b1 && rdy) begin
      hs_log.push_back(int'(evt_id) * 4 + int'(evt_press) * 2 + int'(evt_long));
      hs_cyc.push_back(cyc);
      $display("evt cyc=%0d id=%0d press=%0d long=%0d", cyc, evt_id, evt_press, evt_long);
    end
    @(posedge clk);
    model_edge(raw, rdy);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    btn_raw = '0; evt_ready = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_level", btn_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_press", evt_press, 0);
    chk("rst_long", evt_long, 0);
    chk("rst_ovf", evt_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic int log_at(input int i);
    return (hs_log.size() > i) ? hs_log[i] : -1;
  endfunction

  initial begin
    logic [N-1:0] r;
    bit           stall;

    // Idle buttons: nothing happens.
    do_reset();
    for (int i = 0; i < 100; i++) step('0, 1'b1);
    chk("t1_events", hs_log.size(), 0);
    chk("t1_ovf", evt_ovf, 0);

    // Single press then release on button 1.
    for (int i = 0; i < 40; i++) step(4'b0010, 1'b1);
    chk("t2_level", btn_level[1], 1);
    chk("t2_count", hs_log.size(), 1);
    chk("t2_press_evt", log_at(0), 1 * 4 + 2);
    for (int i = 0; i < 40; i++) step('0, 1'b1);
    chk("t2_released", btn_level[1], 0);
    chk("t2_release_evt", log_at(1), 1 * 4 + 0);

    // Two-tick bounce is filtered out.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b1);
    for (int i = 0; i < 40; i++) step('0, 1'b1);
    chk("t3_events", hs_log.size(), 0);
    chk("t3_level", btn_level, 0);

    // Simultaneous presses drain back-to-back in round-robin order.
    do_reset();
    for (int i = 0; i < 40; i++) step(4'b1101, 1'b1);
    chk("t4_count", hs_log.size(), 3);
    chk("t4_first", log_at(0), 0 * 4 + 2);
    chk("t4_second", log_at(1), 2 * 4 + 2);
    chk("t4_third", log_at(2), 3 * 4 + 2);
    chk("t4_b2b_a", (hs_cyc.size() > 2) ? hs_cyc[1] - hs_cyc[0] : -1, 1);
    chk("t4_b2b_b", (hs_cyc.size() > 2) ? hs_cyc[2] - hs_cyc[1] : -1, 1);
    for (int i = 0; i < 40; i++) step('0, 1'b1);
    chk("t4_rel_first", log_at(3), 0 * 4);
    chk("t4_rel_second", log_at(4), 2 * 4);
    chk("t4_rel_third", log_at(5), 3 * 4);

    // Stalled consumer: press held, release dropped, overflow flagged.
    do_reset();
    for (int i = 0; i < 30; i++) step(4'b0100, 1'b0);
    for (int i = 0; i < 40; i++) step('0, 1'b0);
    chk("t5_ovf", evt_ovf, 1);
    chk("t5_valid", evt_valid, 1);
    chk("t5_id", evt_id, 2);
    chk("t5_press", evt_press, 1);
    for (int i = 0; i < 10; i++) step('0, 1'b1);
    chk("t5_count", hs_log.size(), 1);
    chk("t5_evt", log_at(0), 2 * 4 + 2);

    // Reset while an event is waiting drops it.
    do_reset();
    for (int i = 0; i < 30; i++) step(4'b0010, 1'b0);
    chk("t6_pending", evt_valid, 1);
    do_reset();
    for (int i = 0; i < 20; i++) step('0, 1'b1);
    chk("t6_dropped", hs_log.size(), 0);

`ifdef BTN_LONG_PRESS_EN
    do_reset();
    for (int i = 0; i < 120; i++) step(4'b1000, 1'b1);
    chk("t7_count", hs_log.size(), 2);
    chk("t7_long", log_at(1), 3 * 4 + 3);
`endif

    // Random traffic with ready stalls and a reset in the middle.
    do_reset();
    r = '0; stall = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        do_reset();
        r = '0;
      end
      if (c % 200 == 0) stall = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
      end
      step(r, stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0));
    end
    chk("rand_activity", hs_log.size() > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
